// File: rtl/tri_batch_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tri_batch_reader_pkg
//  Description : Shared geometry definitions for the clipping stage and the
//                triangle batch reader: batch capacity, default vertex
//                component width, vertex/triangle types and the reader's
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tri_batch_reader_pkg;

    // Batch capacity, shared with the clipping stage that fills the batch.
    localparam int c_MAX_TRIANGLES = 64;

    // Default bits per vertex component.
    localparam int c_VERTEX_WIDTH  = 32;

    typedef struct packed {
        logic [c_VERTEX_WIDTH-1:0] x;
        logic [c_VERTEX_WIDTH-1:0] y;
        logic [c_VERTEX_WIDTH-1:0] z;
        logic [c_VERTEX_WIDTH-1:0] w;
    } vertex_t;

    typedef vertex_t [2:0] triangle_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tri_batch_reader_tri_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tri_mux
//  Description : Combinational MAX_TRIANGLES:1 triangle selector. Picks the
//                three vertices of triangle sel_idx out of the batch arrays.
//                An index at or beyond the batch capacity yields all zeros.
//  Ports       : sel_idx                 - triangle index to select
//                in_v_x/y/z/w            - batch vertex arrays [tri][corner]
//                out_v_x/y/z/w           - selected triangle, corners 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_mux
    import tri_batch_reader_pkg::*;
#(
    parameter int VERTEX_WIDTH  = c_VERTEX_WIDTH,
    parameter int MAX_TRIANGLES = c_MAX_TRIANGLES,
    parameter int CNT_W         = $clog2(MAX_TRIANGLES + 1)
) (
    input  logic [CNT_W-1:0]        sel_idx,
    input  logic [VERTEX_WIDTH-1:0] in_v_x  [MAX_TRIANGLES][3],
    input  logic [VERTEX_WIDTH-1:0] in_v_y  [MAX_TRIANGLES][3],
    input  logic [VERTEX_WIDTH-1:0] in_v_z  [MAX_TRIANGLES][3],
    input  logic [VERTEX_WIDTH-1:0] in_v_w  [MAX_TRIANGLES][3],
    output logic [VERTEX_WIDTH-1:0] out_v_x [3],
    output logic [VERTEX_WIDTH-1:0] out_v_y [3],
    output logic [VERTEX_WIDTH-1:0] out_v_z [3],
    output logic [VERTEX_WIDTH-1:0] out_v_w [3]
);

    // Array slot index is narrower than the count width (count can equal
    // the capacity, a slot index cannot).
    localparam int               c_IDX_W   = (MAX_TRIANGLES > 1) ? $clog2(MAX_TRIANGLES) : 1;
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_TRIANGLES);

    logic [c_IDX_W-1:0] w_slot;
    logic               w_in_range;

    assign w_slot     = sel_idx[c_IDX_W-1:0];
    assign w_in_range = (sel_idx < c_MAX_CNT);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            out_v_x[k] = '0;
            out_v_y[k] = '0;
            out_v_z[k] = '0;
            out_v_w[k] = '0;
            if (w_in_range) begin
                out_v_x[k] = in_v_x[w_slot][k];
                out_v_y[k] = in_v_y[w_slot][k];
                out_v_z[k] = in_v_z[w_slot][k];
                out_v_w[k] = in_v_w[w_slot][k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tri_batch_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tri_batch_reader
//  Description : Read side of the clipping stage's batch buffer. Accepts a
//                completed batch (parallel vertex arrays + count, held
//                stable by the producer), streams its triangles one per
//                valid/ready handshake and pulses batch_ack_o for one cycle
//                once the batch has been fully consumed.
//  Ports       : clk_i, rst_i            - clock, sync active-high reset
//                batch_valid_i           - producer batch ready (IDLE only)
//                batch_count_i           - triangles in batch (clamped)
//                in_v_x/y/z/w            - batch vertex arrays
//                batch_ack_o             - one-cycle batch consumed pulse
//                busy_o                  - not IDLE
//                tri_valid_o/tri_ready_i - triangle stream handshake
//                tri_v_x/y/z/w           - current triangle, corners 0..2
//                tri_last_o              - current triangle is last in batch
//                tri_index_o             - index of current triangle
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_batch_reader
    import tri_batch_reader_pkg::*;
#(
    parameter int VERTEX_WIDTH  = c_VERTEX_WIDTH,
    parameter int MAX_TRIANGLES = c_MAX_TRIANGLES,
    parameter int CNT_W         = $clog2(MAX_TRIANGLES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    batch_valid_i,
    input  logic [CNT_W-1:0]        batch_count_i,
    input  logic [VERTEX_WIDTH-1:0] in_v_x [MAX_TRIANGLES][3],
    input  logic [VERTEX_WIDTH-1:0] in_v_y [MAX_TRIANGLES][3],
    input  logic [VERTEX_WIDTH-1:0] in_v_z [MAX_TRIANGLES][3],
    input  logic [VERTEX_WIDTH-1:0] in_v_w [MAX_TRIANGLES][3],
    output logic                    batch_ack_o,
    output logic                    busy_o,
    output logic                    tri_valid_o,
    input  logic                    tri_ready_i,
    output logic [VERTEX_WIDTH-1:0] tri_v_x [3],
    output logic [VERTEX_WIDTH-1:0] tri_v_y [3],
    output logic [VERTEX_WIDTH-1:0] tri_v_z [3],
    output logic [VERTEX_WIDTH-1:0] tri_v_w [3],
    output logic                    tri_last_o,
    output logic [CNT_W-1:0]        tri_index_o
);

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_TRIANGLES);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_idx_inc;
    logic [CNT_W-1:0] w_sel_idx;
    logic [CNT_W-1:0] w_count_clamped;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_load;

    logic [VERTEX_WIDTH-1:0] w_mux_x [3];
    logic [VERTEX_WIDTH-1:0] w_mux_y [3];
    logic [VERTEX_WIDTH-1:0] w_mux_z [3];
    logic [VERTEX_WIDTH-1:0] w_mux_w [3];
    logic [VERTEX_WIDTH-1:0] r_tri_x [3];
    logic [VERTEX_WIDTH-1:0] r_tri_y [3];
    logic [VERTEX_WIDTH-1:0] r_tri_z [3];
    logic [VERTEX_WIDTH-1:0] r_tri_w [3];

    assign w_count_clamped = (batch_count_i > c_MAX_CNT) ? c_MAX_CNT : batch_count_i;
    assign w_idx_inc       = r_idx + c_ONE;

    // Selector is driven by the index of the triangle about to be loaded,
    // so the output registers capture it on the same edge as the handshake.
    tri_mux #(
        .VERTEX_WIDTH  (VERTEX_WIDTH),
        .MAX_TRIANGLES (MAX_TRIANGLES),
        .CNT_W         (CNT_W)
    ) u_tri_mux (
        .sel_idx (w_sel_idx),
        .in_v_x  (in_v_x),
        .in_v_y  (in_v_y),
        .in_v_z  (in_v_z),
        .in_v_w  (in_v_w),
        .out_v_x (w_mux_x),
        .out_v_y (w_mux_y),
        .out_v_z (w_mux_z),
        .out_v_w (w_mux_w)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_load      = 1'b0;
        w_sel_idx   = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (batch_valid_i) begin
                    w_count_nxt = w_count_clamped;
                    if (w_count_clamped == '0) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_load      = 1'b1;
                        w_sel_idx   = '0;
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (w_count_clamped == c_ONE);
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (r_valid && tri_ready_i) begin
                    // r_last is the registered (idx == count-1) flag.
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_load      = 1'b1;
                        w_sel_idx   = w_idx_inc;
                        w_idx_nxt   = w_idx_inc;
                        w_last_nxt  = (w_idx_inc == (r_count - c_ONE));
                    end
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_tri_x[k] <= '0;
                r_tri_y[k] <= '0;
                r_tri_z[k] <= '0;
                r_tri_w[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            if (w_load) begin
                for (int k = 0; k < 3; k++) begin
                    r_tri_x[k] <= w_mux_x[k];
                    r_tri_y[k] <= w_mux_y[k];
                    r_tri_z[k] <= w_mux_z[k];
                    r_tri_w[k] <= w_mux_w[k];
                end
            end
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign batch_ack_o = (r_state == ST_ACK);
    assign tri_valid_o = r_valid;
    assign tri_last_o  = r_last;
    assign tri_index_o = r_idx;
    assign tri_v_x     = r_tri_x;
    assign tri_v_y     = r_tri_y;
    assign tri_v_z     = r_tri_z;
    assign tri_v_w     = r_tri_w;

endmodule
`default_nettype wire

// File: tb/tb_tri_batch_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tri_batch_reader
//  Description : Self-checking bench for tri_batch_reader. Random batches are
//                streamed under random back-pressure; a reference model that
//                only tracks "how many triangles have been handed over" says
//                which triangle, flags and ack must be visible each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_batch_reader;

    localparam int c_VW   = 32;
    localparam int c_MAXT = 64;
    localparam int c_CW   = $clog2(c_MAXT + 1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             batch_valid_i;
    logic [c_CW-1:0]  batch_count_i;
    logic [c_VW-1:0]  in_v_x [c_MAXT][3];
    logic [c_VW-1:0]  in_v_y [c_MAXT][3];
    logic [c_VW-1:0]  in_v_z [c_MAXT][3];
    logic [c_VW-1:0]  in_v_w [c_MAXT][3];
    logic             batch_ack_o;
    logic             busy_o;
    logic             tri_valid_o;
    logic             tri_ready_i;
    logic [c_VW-1:0]  tri_v_x [3];
    logic [c_VW-1:0]  tri_v_y [3];
    logic [c_VW-1:0]  tri_v_z [3];
    logic [c_VW-1:0]  tri_v_w [3];
    logic             tri_last_o;
    logic [c_CW-1:0]  tri_index_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk_i = ~clk_i;

    tri_batch_reader #(
        .VERTEX_WIDTH  (c_VW),
        .MAX_TRIANGLES (c_MAXT),
        .CNT_W         (c_CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .batch_valid_i (batch_valid_i),
        .batch_count_i (batch_count_i),
        .in_v_x        (in_v_x),
        .in_v_y        (in_v_y),
        .in_v_z        (in_v_z),
        .in_v_w        (in_v_w),
        .batch_ack_o   (batch_ack_o),
        .busy_o        (busy_o),
        .tri_valid_o   (tri_valid_o),
        .tri_ready_i   (tri_ready_i),
        .tri_v_x       (tri_v_x),
        .tri_v_y       (tri_v_y),
        .tri_v_z       (tri_v_z),
        .tri_v_w       (tri_v_w),
        .tri_last_o    (tri_last_o),
        .tri_index_o   (tri_index_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic check_tri(input int k);
        for (int c = 0; c < 3; c++) begin
            check_val("tri_v_x", tri_v_x[c], in_v_x[k][c]);
            check_val("tri_v_y", tri_v_y[c], in_v_y[k][c]);
            check_val("tri_v_z", tri_v_z[c], in_v_z[k][c]);
            check_val("tri_v_w", tri_v_w[c], in_v_w[k][c]);
        end
    endtask

    task automatic check_all_zero();
        check_val("rst_valid", tri_valid_o, 1'b0);
        check_val("rst_last",  tri_last_o,  1'b0);
        check_val("rst_index", tri_index_o, '0);
        check_val("rst_ack",   batch_ack_o, 1'b0);
        check_val("rst_busy",  busy_o,      1'b0);
        for (int c = 0; c < 3; c++) begin
            check_val("rst_vx", tri_v_x[c], '0);
            check_val("rst_vy", tri_v_y[c], '0);
            check_val("rst_vz", tri_v_z[c], '0);
            check_val("rst_vw", tri_v_w[c], '0);
        end
    endtask

    // One batch. Entry/exit point: just after an edge with the DUT idle.
    // pct: ready probability; stall: cycles of forced ready=0 after first
    // valid; abort_after: assert reset once that many triangles have fired
    // (-1 = never); hold: leave batch_valid_i high throughout.
    task automatic run_batch(input int count, input int pct, input int stall,
                             input int abort_after, input bit hold, output int ack_cyc);
        int  exp_n;
        int  k;
        int  t;
        int  first_cyc;
        logic r;
        ack_cyc = -1;
        for (int i = 0; i < c_MAXT; i++) begin
            for (int c = 0; c < 3; c++) begin
                in_v_x[i][c] = $urandom;
                in_v_y[i][c] = $urandom;
                in_v_z[i][c] = $urandom;
                in_v_w[i][c] = $urandom;
            end
        end
        exp_n         = (count > c_MAXT) ? c_MAXT : count;
        batch_count_i = c_CW'(count);
        batch_valid_i = 1'b1;
        tri_ready_i   = 1'($urandom_range(0, 1));
        tick();
        if (!hold) batch_valid_i = 1'b0;
        first_cyc = cyc;
        k = 0;
        t = 0;
        while (k < exp_n) begin
            if (t > 2000) begin
                check_val("timeout", 64'(t), 64'd0);
                return;
            end
            check_val("valid", tri_valid_o, 1'b1);
            check_val("busy",  busy_o,      1'b1);
            check_val("ack",   batch_ack_o, 1'b0);
            check_val("index", tri_index_o, 64'(k));
            check_val("last",  tri_last_o,  (k == exp_n - 1));
            check_tri(k);
            if (abort_after == k) begin
                batch_valid_i = 1'b0;
                rst_i         = 1'b1;
                tri_ready_i   = 1'b1;
                tick();
                rst_i = 1'b0;
                check_all_zero();
                for (int j = 0; j < 3; j++) begin
                    tick();
                    check_val("post_rst_valid", tri_valid_o, 1'b0);
                    check_val("post_rst_busy",  busy_o,      1'b0);
                    check_val("post_rst_ack",   batch_ack_o, 1'b0);
                end
                return;
            end
            r = (t < stall) ? 1'b0 : ($urandom_range(0, 99) < pct);
            tri_ready_i = r;
            tick();
            t++;
            if (r) k++;
        end
        // Every triangle handed over: this cycle is the acknowledge.
        check_val("ack_pulse",  batch_ack_o, 1'b1);
        check_val("ack_busy",   busy_o,      1'b1);
        check_val("ack_valid",  tri_valid_o, 1'b0);
        ack_cyc = cyc;
        if (pct >= 100 && stall == 0)
            check_val("ack_latency", 64'(ack_cyc - first_cyc), 64'(exp_n));
        tri_ready_i = 1'($urandom_range(0, 1));
        tick();
        check_val("idle_ack",   batch_ack_o, 1'b0);
        check_val("idle_busy",  busy_o,      1'b0);
        check_val("idle_valid", tri_valid_o, 1'b0);
    endtask

    initial begin
        int a;
        int a1;
        int a2;
        rst_i         = 1'b1;
        batch_valid_i = 1'b0;
        batch_count_i = '0;
        tri_ready_i   = 1'b0;
        for (int i = 0; i < c_MAXT; i++) begin
            for (int c = 0; c < 3; c++) begin
                in_v_x[i][c] = '0;
                in_v_y[i][c] = '0;
                in_v_z[i][c] = '0;
                in_v_w[i][c] = '0;
            end
        end
        repeat (3) tick();
        check_all_zero();
        rst_i = 1'b0;
        tick();

        run_batch(3,  100, 0, -1, 1'b0, a);   // back-to-back stream
        run_batch(2,  50,  4, -1, 1'b0, a);   // initial stall, then pulses
        run_batch(0,  100, 0, -1, 1'b0, a);   // empty batch
        run_batch(70, 100, 0, -1, 1'b0, a);   // clamps to capacity
        run_batch(64, 60,  1, -1, 1'b0, a);   // exactly full
        run_batch(10, 100, 0,  5, 1'b0, a);   // reset mid-batch
        run_batch(1,  100, 0, -1, 1'b0, a);   // recovers normally

        // Producer keeps batch_valid_i high across two batches.
        run_batch(1, 100, 0, -1, 1'b1, a1);
        run_batch(1, 100, 0, -1, 1'b1, a2);
        batch_valid_i = 1'b0;
        check_val("ack_gap", 64'(a2 - a1), 64'd3);

        for (int n = 0; n < 12; n++) begin
            run_batch(int'($urandom_range(0, 70)), int'($urandom_range(20, 100)),
                      int'($urandom_range(0, 3)), -1, 1'b0, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
